// File: rtl/ysyx_22040895_regfile_mp_if.sv
// Bus bundle for the ysyx_22040895 multi-port register file:
// read ports, two write ports, reserve request, scoreboard and ready.
interface ysyx_22040895_regfile_mp_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int NR     = 2
);
   localparam int DEPTH = 1 << ADDR_W;

   logic                   ready_o;
   logic [NR-1:0]          re_i;
   logic [NR*ADDR_W-1:0]   raddr_i;
   logic [NR*DATA_W-1:0]   rdata_o;
   logic                   we0_i;
   logic                   we1_i;
   logic [ADDR_W-1:0]      waddr0_i;
   logic [ADDR_W-1:0]      waddr1_i;
   logic [DATA_W-1:0]      wdata0_i;
   logic [DATA_W-1:0]      wdata1_i;
   logic                   rsv_i;
   logic [ADDR_W-1:0]      rsv_addr_i;
   logic [DEPTH-1:0]       busy_o;

   modport master (
      input  ready_o, rdata_o, busy_o,
      output re_i, raddr_i,
      output we0_i, we1_i, waddr0_i, waddr1_i, wdata0_i, wdata1_i,
      output rsv_i, rsv_addr_i
   );

   modport slave (
      output ready_o, rdata_o, busy_o,
      input  re_i, raddr_i,
      input  we0_i, we1_i, waddr0_i, waddr1_i, wdata0_i, wdata1_i,
      input  rsv_i, rsv_addr_i
   );
endinterface

// File: rtl/ysyx_22040895_regfile_mp.sv
// Multi-port GPR file: NR read ports, two prioritised writes, busy scoreboard,
// sequential post-reset clear. Define YSYX_22040895_RF_BYPASS_EN for write->read bypass.
module ysyx_22040895_regfile_mp #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int NR     = 2
) (
   input logic clk,
   input logic rst,
   ysyx_22040895_regfile_mp_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [DEPTH-1:0]    busy_q, busy_d;
   logic [DATA_W-1:0]   regs_q [DEPTH];
   logic                wen0, wen1;
   logic [NR*DATA_W-1:0] rdata;

   always_comb begin
      wen0 = (state_q == RUN) && bus.we0_i && (bus.waddr0_i != '0);
      wen1 = (state_q == RUN) && bus.we1_i && (bus.waddr1_i != '0);
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == INIT) begin
         // counter wraps to 0 naturally on the last clear
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (&clr_cnt_q) state_d = RUN;
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (state_q == RUN) begin
         if (wen0) busy_d[bus.waddr0_i] = 1'b0;
         if (wen1) busy_d[bus.waddr1_i] = 1'b0;
         // a new reservation supersedes a retiring writer
         if (bus.rsv_i && (bus.rsv_addr_i != '0))
            busy_d[bus.rsv_addr_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= INIT;
         clr_cnt_q <= '0;
         busy_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
      end
   end

   // Array has no reset; it is cleared one entry per cycle in INIT.
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         regs_q[clr_cnt_q] <= '0;
      end else begin
         if (wen0) regs_q[bus.waddr0_i] <= bus.wdata0_i;
         if (wen1) regs_q[bus.waddr1_i] <= bus.wdata1_i;
      end
   end

   always_comb begin
      rdata = '0;
      for (int k = 0; k < NR; k++) begin
         if ((state_q == RUN) && bus.re_i[k] &&
             (bus.raddr_i[k*ADDR_W +: ADDR_W] != '0)) begin
            rdata[k*DATA_W +: DATA_W] = regs_q[bus.raddr_i[k*ADDR_W +: ADDR_W]];
`ifdef YSYX_22040895_RF_BYPASS_EN
            if (wen1 && (bus.waddr1_i == bus.raddr_i[k*ADDR_W +: ADDR_W]))
               rdata[k*DATA_W +: DATA_W] = bus.wdata1_i;
            else if (wen0 && (bus.waddr0_i == bus.raddr_i[k*ADDR_W +: ADDR_W]))
               rdata[k*DATA_W +: DATA_W] = bus.wdata0_i;
`endif
         end
      end
   end

   assign bus.rdata_o = rdata;
   assign bus.busy_o  = busy_q;
   assign bus.ready_o = (state_q == RUN);
endmodule

// File: tb/tb_ysyx_22040895_regfile_mp.sv
// Self-checking bench for ysyx_22040895_regfile_mp against a
// behavioural array/scoreboard model; honours YSYX_22040895_RF_BYPASS_EN.
module tb_ysyx_22040895_regfile_mp;
   localparam int DW = 64;
   localparam int AW = 5;
   localparam int NP = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   logic [DW-1:0] m_regs [32];
   logic [31:0]   m_busy;

   ysyx_22040895_regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NR(NP)) bus ();

   ysyx_22040895_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NR(NP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic idle();
      bus.re_i       = '0;
      bus.raddr_i    = '0;
      bus.we0_i      = 1'b0;
      bus.we1_i      = 1'b0;
      bus.waddr0_i   = '0;
      bus.waddr1_i   = '0;
      bus.wdata0_i   = '0;
      bus.wdata1_i   = '0;
      bus.rsv_i      = 1'b0;
      bus.rsv_addr_i = '0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = '0;
   endtask

   // Architectural effect of one RUN-state clock edge.
   task automatic model_edge();
      if (bus.we0_i && bus.waddr0_i != 0) begin
         m_regs[bus.waddr0_i] = bus.wdata0_i;
         m_busy[bus.waddr0_i] = 1'b0;
      end
      if (bus.we1_i && bus.waddr1_i != 0) begin
         m_regs[bus.waddr1_i] = bus.wdata1_i;
         m_busy[bus.waddr1_i] = 1'b0;
      end
      if (bus.rsv_i && bus.rsv_addr_i != 0) m_busy[bus.rsv_addr_i] = 1'b1;
   endtask

   function automatic logic [DW-1:0] model_read(int k);
      logic [AW-1:0] a;
      logic [DW-1:0] v;
      a = bus.raddr_i[k*AW +: AW];
      if (!bus.re_i[k] || a == 0) return '0;
      v = m_regs[a];
`ifdef YSYX_22040895_RF_BYPASS_EN
      if (bus.we0_i && bus.waddr0_i == a) v = bus.wdata0_i;
      if (bus.we1_i && bus.waddr1_i == a) v = bus.wdata1_i;
`endif
      return v;
   endfunction

   task automatic run_clear(string tag);
      for (int i = 1; i <= 32; i++) begin
         @(posedge clk);
         #1;
         n_chk++;
         if (bus.ready_o !== (i == 32)) begin
            n_fail++;
            $display("FAIL %s_ready edge=%0d got=%b want=%b", tag, i,
                     bus.ready_o, (i == 32));
         end
         if (i == 32) bus.we0_i = 1'b0;
      end
      model_clear();
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      bus.we0_i = 1'b1;
      bus.waddr0_i = 5'd3;
      bus.wdata0_i = 64'hAA;
      bus.re_i = 2'b01;
      bus.raddr_i = {5'd0, 5'd3};
      #2;
      n_chk++;
      if (bus.ready_o !== 1'b0 || bus.busy_o !== '0) begin
         n_fail++;
         $display("FAIL reset_state ready=%b busy=%h want 0/0", bus.ready_o, bus.busy_o);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_chk++;
      if (bus.rdata_o[0 +: DW] !== '0) begin
         n_fail++;
         $display("FAIL init_rdata got=%h want=0", bus.rdata_o[0 +: DW]);
      end
      run_clear("reset");
      #1;
      n_chk++;
      if (bus.rdata_o[0 +: DW] !== '0 || bus.busy_o !== '0) begin
         n_fail++;
         $display("FAIL reset_x3 rdata=%h busy=%h want 0/0",
                  bus.rdata_o[0 +: DW], bus.busy_o);
      end
   endtask

   task automatic test_dual_write();
      @(negedge clk);
      idle();
      bus.we0_i = 1'b1; bus.waddr0_i = 5'd5; bus.wdata0_i = 64'h1111;
      bus.we1_i = 1'b1; bus.waddr1_i = 5'd5; bus.wdata1_i = 64'h2222;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      idle();
      bus.re_i = 2'b11;
      bus.raddr_i = {5'd5, 5'd5};
      #1;
      for (int k = 0; k < NP; k++) begin
         n_chk++;
         if (bus.rdata_o[k*DW +: DW] !== 64'h2222) begin
            n_fail++;
            $display("FAIL dual_write port=%0d got=%h want=2222", k, bus.rdata_o[k*DW +: DW]);
         end
      end
   endtask

   task automatic test_x0();
      @(negedge clk);
      idle();
      bus.we0_i = 1'b1; bus.waddr0_i = 5'd0; bus.wdata0_i = 64'hFFFF;
      bus.we1_i = 1'b1; bus.waddr1_i = 5'd0; bus.wdata1_i = 64'hFFFF;
      bus.rsv_i = 1'b1; bus.rsv_addr_i = 5'd0;
      bus.re_i = 2'b11;
      bus.raddr_i = {5'd0, 5'd0};
      @(posedge clk);
      model_edge();
      @(negedge clk);
      idle();
      bus.re_i = 2'b11;
      #1;
      n_chk++;
      if (bus.rdata_o !== '0 || bus.busy_o[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL x0 rdata=%h busy0=%b want 0/0", bus.rdata_o, bus.busy_o[0]);
      end
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      idle();
      bus.rsv_i = 1'b1; bus.rsv_addr_i = 5'd7;
      @(posedge clk);
      model_edge();
      #1;
      n_chk++;
      if (bus.busy_o[7] !== 1'b1) begin
         n_fail++;
         $display("FAIL sb_reserve got=%b want=1", bus.busy_o[7]);
      end
      @(negedge clk);
      idle();
      bus.we0_i = 1'b1; bus.waddr0_i = 5'd7; bus.wdata0_i = 64'h77;
      @(posedge clk);
      model_edge();
      #1;
      n_chk++;
      if (bus.busy_o[7] !== 1'b0) begin
         n_fail++;
         $display("FAIL sb_release got=%b want=0", bus.busy_o[7]);
      end
      @(negedge clk);
      idle();
      bus.we1_i = 1'b1; bus.waddr1_i = 5'd7; bus.wdata1_i = 64'h77;
      bus.rsv_i = 1'b1; bus.rsv_addr_i = 5'd7;
      @(posedge clk);
      model_edge();
      #1;
      n_chk++;
      if (bus.busy_o[7] !== 1'b1) begin
         n_fail++;
         $display("FAIL sb_set_wins got=%b want=1", bus.busy_o[7]);
      end
   endtask

   task automatic test_bypass();
      logic [DW-1:0] exp;
      @(negedge clk);
      idle();
      bus.we0_i = 1'b1; bus.waddr0_i = 5'd9; bus.wdata0_i = 64'h55;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      idle();
      bus.we0_i = 1'b1; bus.waddr0_i = 5'd9; bus.wdata0_i = 64'h99;
      bus.re_i = 2'b10;
      bus.raddr_i = {5'd9, 5'd0};
`ifdef YSYX_22040895_RF_BYPASS_EN
      exp = 64'h99;
`else
      exp = 64'h55;
`endif
      #1;
      n_chk++;
      if (bus.rdata_o[DW +: DW] !== exp) begin
         n_fail++;
         $display("FAIL bypass_same got=%h want=%h", bus.rdata_o[DW +: DW], exp);
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      bus.we0_i = 1'b0;
      #1;
      n_chk++;
      if (bus.rdata_o[DW +: DW] !== 64'h99) begin
         n_fail++;
         $display("FAIL bypass_next got=%h want=99", bus.rdata_o[DW +: DW]);
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      idle();
      #1;
      n_chk++;
      if (bus.busy_o !== m_busy || m_busy !== 32'h80) begin
         n_fail++;
         $display("FAIL mid_pre_busy got=%h model=%h want=80", bus.busy_o, m_busy);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      n_chk++;
      if (bus.ready_o !== 1'b0 || bus.busy_o !== '0) begin
         n_fail++;
         $display("FAIL mid_async ready=%b busy=%h want 0/0", bus.ready_o, bus.busy_o);
      end
      #4 rst = 1'b0;
      run_clear("mid");
      bus.re_i = 2'b11;
      bus.raddr_i = {5'd9, 5'd7};
      #1;
      n_chk++;
      if (bus.rdata_o !== '0) begin
         n_fail++;
         $display("FAIL mid_cleared rdata=%h want=0", bus.rdata_o);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] exp;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         bus.we0_i      = 1'($urandom);
         bus.we1_i      = 1'($urandom);
         bus.waddr0_i   = 5'($urandom_range(0, 7));
         bus.waddr1_i   = 5'(($urandom & 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
         bus.wdata0_i   = {$urandom, $urandom};
         bus.wdata1_i   = {$urandom, $urandom};
         bus.rsv_i      = 1'($urandom);
         bus.rsv_addr_i = 5'($urandom_range(0, 7));
         bus.re_i       = 2'($urandom);
         bus.raddr_i    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
         #1;
         for (int k = 0; k < NP; k++) begin
            exp = model_read(k);
            n_chk++;
            if (bus.rdata_o[k*DW +: DW] !== exp) begin
               n_fail++;
               $display("FAIL rnd_read c=%0d port=%0d got=%h want=%h", c, k,
                        bus.rdata_o[k*DW +: DW], exp);
            end
         end
         @(posedge clk);
         model_edge();
         #1;
         n_chk++;
         if (bus.busy_o !== m_busy || bus.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rnd_busy c=%0d got=%h want=%h ready=%b", c,
                     bus.busy_o, m_busy, bus.ready_o);
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_dual_write();
      test_x0();
      test_scoreboard();
      test_bypass();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ysyx_22040895_regfile_mp.md
# ysyx_22040895_regfile_mp

Parametrised multi-port integer register file for the ysyx_22040895 core, the next-generation replacement for the single-write, two-read GPR array. It provides NR combinational read ports and two prioritised write ports. It also holds a per-register busy scoreboard for in-flight writebacks and runs a sequential self-clear after reset. It sits between decode/issue, which reads and reserves registers, and writeback, which writes registers and releases them.

## Interface
- DATA_W, 64: register width in bits.
- ADDR_W, 5: register address width; DEPTH = 2**ADDR_W registers.
- NR, 2: number of read ports, 1..4.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ready_o  out  1  high once the post-reset clear has finished.
- re_i  in  NR  read enable, one bit per port.
- raddr_i  in  NR*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rdata_o  out  NR*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- we0_i, we1_i  in  1  write enables for port 0 and port 1.
- waddr0_i, waddr1_i  in  ADDR_W  write addresses.
- wdata0_i, wdata1_i  in  DATA_W  write data.
- rsv_i  in  1  reserve request: mark a destination as pending.
- rsv_addr_i  in  ADDR_W  register address to reserve.
- busy_o  out  DEPTH  registered scoreboard, one bit per register.

## Operation
- States: INIT and RUN. A 1-bit state register plus an ADDR_W-bit clear counter clr_cnt.
- Reset (asynchronous):
  - state=INIT, clr_cnt=0, ready_o=0, busy_o=0.
  - Register contents are not reset directly.
- INIT:
  - Each cycle, regs[clr_cnt] is written with 0 and clr_cnt is incremented.
  - When clr_cnt==DEPTH-1 is cleared, the next state is RUN and ready_o is registered to 1.
  - All writes and reserves are ignored.
  - rdata_o is all 0.
- RUN, writes:
  - Port p writes regs[waddrp_i] when wep_i is high and waddrp_i!=0.
  - If both ports target the same address, port 1 wins.
- RUN, reads:
  - rdata for port k is 0 if re_i[k]==0 or raddr==0.
  - Otherwise it is regs[raddr].
- Scoreboard:
  - An accepted write on either port clears busy[waddr].
  - rsv_i with rsv_addr_i!=0 sets busy[rsv_addr_i].
  - If a set and a clear hit the same address in one cycle, the set wins: the new producer supersedes the retiring one.
  - Reserving an already-busy register leaves it busy.
  - busy_o[0] is constant 0.
  - Writes with we=0 or to address 0 never alter busy.
- Register 0 always reads 0 and is never written or reserved.

## Timing
- Read latency is 0 cycles: combinational from raddr_i, re_i and the array.
- Write latency is 1 cycle: data is visible to reads in the cycle after the write edge, unless bypass is enabled.
- busy_o changes 1 cycle after the rsv or write edge.
- ready_o rises exactly DEPTH cycles after the first rising clk edge with rst low (32 for the default ADDR_W).
- If rst is asserted mid-INIT or in RUN, the block returns to INIT immediately (asynchronously) and the clear restarts from 0.
- clr_cnt wraps to 0 on leaving INIT. There is no wrap-around in RUN.

## Configuration
- YSYX_22040895_RF_BYPASS_EN defined:
  - In RUN, a read port whose address matches an accepted write in the same cycle returns that write's data.
  - If both write ports match, wdata1_i is returned, consistent with write priority.
  - Address 0 and disabled ports still return 0.
- Undefined: the read returns the pre-write array value, and the new value is visible the next cycle.
- Scoreboard behaviour is identical in both builds.

## Test plan
- Reset:
  - Stimulus: assert rst, release, hold we0_i=1, waddr0_i=3, wdata0_i=0xAA for 32 cycles.
  - Required: ready_o=0 for 32 cycles then 1; read of x3 returns 0; busy_o=0.
- Dual write, same address:
  - Stimulus: we0 writes x5=0x1111 and we1 writes x5=0x2222 in one cycle.
  - Required: next cycle x5 reads 0x2222 on every port.
- x0:
  - Stimulus: write x0=0xFFFF and reserve x0.
  - Required: reads of x0 return 0; busy_o[0]=0.
- Scoreboard:
  - Stimulus: reserve x7; next cycle write x7=0x77.
  - Required: busy_o[7]=1 for one cycle, then 0.
  - Stimulus: simultaneous reserve and write on x7.
  - Required: busy_o[7] stays 1.
- Bypass:
  - Stimulus: write x9=0x99 while reading x9 on port 1.
  - Required: rdata returns 0x99 in the same cycle with YSYX_22040895_RF_BYPASS_EN defined; returns the old value without it.
- Mid-run reset:
  - Stimulus: pulse rst for half a cycle while busy_o=0x80.
  - Required: ready_o and busy_o drop to 0 immediately; the 32-cycle clear reruns.
